// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : fetch PC sequencer feeding a prefetch FIFO to decode.
// Optional macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MEM_BYTES  = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fsm_e;

  fsm_e             fsm_q;
  logic [31:0]      fpc_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q    [FIFO_DEPTH];
  logic        fifo_fault_q [FIFO_DEPTH];

  logic pop;
  logic push;
  logic fault;

  always_comb begin
    pop   = instr_valid_o & instr_ready_i;
    push  = (fsm_q == RUN) & fetch_en_i & ~redirect_i & ((count_q < DEPTH_C) | pop);
    fault = (fpc_q >= MEM_LIMIT) | (fpc_q[1:0] != 2'b00);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc_q    <= RESET_PC;
      fsm_q    <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      // A concurrent pop is simply absorbed by the flush.
      fpc_q    <= redirect_pc_i;
      fsm_q    <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= fault ? 32'h0 : imem_rdata_i;
        fifo_pc_q[wr_ptr_q]    <= fpc_q;
        fifo_fault_q[wr_ptr_q] <= fault;
        wr_ptr_q               <= wr_ptr_q + 1'b1;
        fpc_q                  <= fpc_q + 32'd4;
        if (fault) begin
          fsm_q <= HALT;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Head fields read zero whenever the FIFO is empty.
  always_comb begin
    imem_addr_o   = fpc_q;
    instr_valid_o = (count_q != '0);
    instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
    instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    instr_fault_o = instr_valid_o ? fifo_fault_q[rd_ptr_q] : 1'b0;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop & ~instr_fault_o) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (instr_valid_o & ~instr_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;
`else
  // Counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] mem [1024];
  int n_cmp;
  int n_err;

  assign imem_rdata = mem[imem_addr[11:2]];

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .MEM_BYTES  (4096)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_fault_o (instr_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_o (fetch_count),
    .stall_count_o (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_instr, input logic e_fault);
    check_eq({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, ".pc"},    instr_pc, e_pc);
    check_eq({tag, ".instr"}, instr, e_instr);
    check_eq({tag, ".fault"}, {31'd0, instr_fault}, {31'd0, e_fault});
  endtask

  task automatic check_empty(input string tag, input logic [31:0] e_addr);
    check_eq({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    check_eq({tag, ".addr"},  imem_addr, e_addr);
  endtask

  logic [31:0] exp_w [3];

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'd11;
    mem[1] = 32'd22;
    mem[2] = 32'd33;
    mem[3] = 32'd44;
    exp_w[0] = 32'd11;
    exp_w[1] = 32'd22;
    exp_w[2] = 32'd33;

    rst = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    check_empty("rst", 32'h0);
    check_eq("rst.instr", instr, 32'h0);
    check_eq("rst.pc", instr_pc, 32'h0);
    check_eq("rst.fault", {31'd0, instr_fault}, 32'd0);

    // Streaming fetch, one word per cycle.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_head($sformatf("stream%0d", k), 32'(4 * k), exp_w[k], 1'b0);
    end
    check_eq("stream.addr", imem_addr, 32'd12);

    // Back-pressure fills the FIFO; fetch PC holds.
    rst = 1'b1; instr_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_head("full", 32'd0, 32'd11, 1'b0);
    check_eq("full.addr", imem_addr, 32'd8);
    instr_ready = 1'b1;
    step();
    check_head("drain1", 32'd4, 32'd22, 1'b0);
    step();
    check_head("drain2", 32'd8, 32'd33, 1'b0);
    check_eq("drain.addr", imem_addr, 32'd16);

    // Redirect with two entries queued.
    redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b0;
    step();
    check_empty("redir40", 32'h40);
    redirect = 1'b0; instr_ready = 1'b1;
    step();
    check_head("redir40.head", 32'h40, 32'hA500_0010, 1'b0);

    // Running off the end of memory.
    redirect = 1'b1; redirect_pc = 32'hFFC;
    step();
    check_empty("redirFFC", 32'hFFC);
    redirect = 1'b0;
    step();
    check_head("lastword", 32'hFFC, 32'hA500_03FF, 1'b0);
    step();
    check_head("oor", 32'h1000, 32'h0, 1'b1);
    check_eq("oor.addr", imem_addr, 32'h1004);
    step();
    check_empty("halt1", 32'h1004);
    step();
    check_empty("halt2", 32'h1004);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    check_empty("resume", 32'h0);
    redirect = 1'b0;
    step();
    check_head("resume.head", 32'h0, 32'd11, 1'b0);

    // Misaligned target, then reset out of HALT.
    redirect = 1'b1; redirect_pc = 32'h6; instr_ready = 1'b0;
    step();
    check_empty("redir6", 32'h6);
    redirect = 1'b0;
    step();
    check_head("misal", 32'h6, 32'h0, 1'b1);
    check_eq("misal.addr", imem_addr, 32'hA);
    step();
    check_head("misal.hold", 32'h6, 32'h0, 1'b1);
    check_eq("misal.hold.addr", imem_addr, 32'hA);
    rst = 1'b1;
    step();
    check_empty("midrst", 32'h0);
    check_eq("midrst.pc", instr_pc, 32'h0);
    check_eq("midrst.fault", {31'd0, instr_fault}, 32'd0);
    rst = 1'b0; instr_ready = 1'b1;
    step();
    check_head("postrst", 32'h0, 32'd11, 1'b0);

    // Fetch disabled: pops continue, redirect still lands.
    fetch_en = 1'b0;
    step();
    check_empty("dis", 32'd4);
    redirect = 1'b1; redirect_pc = 32'h8;
    step();
    check_empty("dis.redir", 32'h8);
    redirect = 1'b0;
    step();
    check_empty("dis.hold", 32'h8);
    fetch_en = 1'b1;
    step();
    check_head("en", 32'h8, 32'd33, 1'b0);

`ifdef FETCH_PERF_CNT_EN
    rst = 1'b1;
    step();
    check_eq("perf.rst.fetch", fetch_count, 32'd0);
    check_eq("perf.rst.stall", stall_count, 32'd0);
    rst = 1'b0; instr_ready = 1'b1;
    step();
    for (int k = 0; k < 10; k++) step();
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check_eq("perf.fetch", fetch_count, 32'd10);
    check_eq("perf.stall", stall_count, 32'd3);
    rst = 1'b1;
    step();
    check_eq("perf.clr.fetch", fetch_count, 32'd0);
    check_eq("perf.clr.stall", stall_count, 32'd0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
